// File: rtl/tinker_pkg.sv
// Shared constants for the tinker core: register-file geometry, opcode map and the
// predicate ID uses to decide whether an instruction claims a destination register.
package tinker_pkg;

    localparam int unsigned     TK_XLEN   = 64;
    localparam int unsigned     TK_NREGS  = 32;
    localparam int unsigned     TK_NRD    = 3;
    localparam int unsigned     TK_MAXINF = 3;
    localparam int unsigned     TK_SP_IDX = 31;
    localparam longint unsigned TK_SP_RST = 64'd524288;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_AND    = 5'h00;
    localparam opcode_t OP_OR     = 5'h01;
    localparam opcode_t OP_XOR    = 5'h02;
    localparam opcode_t OP_NOT    = 5'h03;
    localparam opcode_t OP_BR     = 5'h08;
    localparam opcode_t OP_CALL   = 5'h0C;
    localparam opcode_t OP_RETURN = 5'h0D;
    localparam opcode_t OP_PRIV   = 5'h0F;
    localparam opcode_t OP_MOV_LD = 5'h10;
    localparam opcode_t OP_MOV_ST = 5'h13;
    localparam opcode_t OP_ADD    = 5'h18;

    // Control-flow ops (0x08-0x0F) and the memory store leave the register file untouched.
    function automatic logic op_writes_reg(input opcode_t op);
        if (op >= OP_BR && op <= OP_PRIV) return 1'b0;
        if (op == OP_MOV_ST)              return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/tinker_sb_counter.sv
// In-flight writer counter for one register: saturating up, two independent decrements.
// full/underflow are combinational on the net (post-decrement) count; state updates next edge.
module tinker_sb_counter #(
    parameter int unsigned MAXINF = 3,
    parameter int unsigned CW     = $clog2(MAXINF + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec1,
    input  logic          dec2,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          underflow
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW+1:0] after_dec, after_inc;

    always_comb begin
        after_dec = {2'b00, cnt_q} - (CW+2)'(dec1) - (CW+2)'(dec2);
        // Same-cycle retirements make room before the new issue is judged.
        full      = $signed(after_dec) >= $signed((CW+2)'(MAXINF));
        after_inc = after_dec + (CW+2)'(inc && !full);
        underflow = after_inc[CW+1];
        cnt_d     = underflow ? '0 : after_inc[CW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tinker_regfile_sb.sv
// Register file with per-register in-flight writer scoreboard and write-through bypass.
// Reads are zero-latency; issue is refused (iss_ready=0) while the destination is at MAXINF writers.
module tinker_regfile_sb
    import tinker_pkg::*;
#(
    parameter int unsigned     XLEN   = TK_XLEN,
    parameter int unsigned     NREGS  = TK_NREGS,
    parameter int unsigned     NRD    = TK_NRD,
    parameter int unsigned     MAXINF = TK_MAXINF,
    parameter int unsigned     SP_IDX = TK_SP_IDX,
    parameter longint unsigned SP_RST = TK_SP_RST,
    localparam int unsigned    AW     = $clog2(NREGS),
    localparam int unsigned    CW     = $clog2(MAXINF + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                kill_valid,
    input  logic [AW-1:0]       kill_addr,
    output logic [XLEN-1:0]     sp_val,
    output logic                sb_err
);

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CW-1:0]   cnt_w  [NREGS];
    logic [NREGS-1:0] full_w, uf_w;
    logic sb_err_q, sb_err_d;
    logic wb_ok, iss_ok, kill_ok;

    assign wb_ok   = wb_we && in_range(wb_addr);
    assign iss_ok  = iss_valid && in_range(iss_addr);
    assign kill_ok = kill_valid && in_range(kill_addr);

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        tinker_sb_counter #(.MAXINF(MAXINF), .CW(CW)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (iss_ok  && iss_addr  == AW'(r)),
            .dec1      (wb_ok   && wb_addr   == AW'(r)),
            .dec2      (kill_ok && kill_addr == AW'(r)),
            .cnt       (cnt_w[r]),
            .full      (full_w[r]),
            .underflow (uf_w[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_ok) regs_d[wb_addr] = wb_data;
        sb_err_d = sb_err_q | (|uf_w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= (r == SP_IDX) ? XLEN'(SP_RST) : '0;
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = rd_addr[i*AW +: AW];
            hit = wb_ok && wb_addr == a;
            if (in_range(a)) begin
                rd_data[i*XLEN +: XLEN] = hit ? wb_data : regs_q[a];
                // The retiring writer is served by the bypass, so it no longer counts as pending.
                rd_busy[i] = cnt_w[a] != CW'(hit);
            end
        end
    end

    assign sp_val    = (wb_ok && wb_addr == AW'(SP_IDX)) ? wb_data : regs_q[SP_IDX];
    assign iss_ready = in_range(iss_addr) ? !full_w[iss_addr] : 1'b1;
    assign sb_err    = sb_err_q;

endmodule
